// File: rtl/reg_file_mp.sv
// Multi-port integer register file with an integrated per-register pending scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      rd_wr_en,
  input  logic [NWR*AW-1:0]   rd_addr,
  input  logic [NWR*XLEN-1:0] rd_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec
);

  // Register n occupies r_regs[n*XLEN +: XLEN].
  logic [NREGS*XLEN-1:0] r_regs;
  logic [NREGS*XLEN-1:0] w_regs_nxt;
  logic [NREGS-1:0]      r_busy;
  logic [NREGS-1:0]      w_busy_nxt;
  logic [NWR-1:0]        w_wr_ok;
  logic                  w_alloc_ok;

  // Writes and allocations of x0 are dropped up front when it is hard-wired.
  always_comb begin
    w_wr_ok = '0;
    for (int j = 0; j < NWR; j++) begin
      w_wr_ok[j] = rd_wr_en[j] &&
                   !((ZERO_REG != 0) && (rd_addr[j*AW +: AW] == '0));
    end
    w_alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
  end

  // Ascending port order lets the highest-index writer win; allocation is
  // applied last so a newly issued producer overrides a same-cycle writeback.
  always_comb begin
    w_regs_nxt = r_regs;
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++) begin
      if (w_wr_ok[j]) begin
        w_regs_nxt[int'(rd_addr[j*AW +: AW])*XLEN +: XLEN] = rd_data[j*XLEN +: XLEN];
        w_busy_nxt[rd_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (w_alloc_ok) begin
      w_busy_nxt[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
      r_busy <= '0;
    end else if (clk_en) begin
      r_regs <= w_regs_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rs_data[i*XLEN +: XLEN] = r_regs[int'(rs_addr[i*AW +: AW])*XLEN +: XLEN];
      rs_busy[i]              = r_busy[rs_addr[i*AW +: AW]];
`ifdef REG_FILE_BYPASS_EN
      // Forwarding is suppressed while in reset so reads stay zero there.
      for (int j = 0; j < NWR; j++) begin
        if (rst_n && clk_en && w_wr_ok[j] &&
            (rd_addr[j*AW +: AW] == rs_addr[i*AW +: AW])) begin
          rs_data[i*XLEN +: XLEN] = rd_data[j*XLEN +: XLEN];
          rs_busy[i]              = w_alloc_ok && (alloc_addr == rs_addr[i*AW +: AW]);
        end
      end
`endif
      if ((ZERO_REG != 0) && (rs_addr[i*AW +: AW] == '0)) begin
        rs_data[i*XLEN +: XLEN] = '0;
        rs_busy[i]              = 1'b0;
      end
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic
// compared against a per-register behavioural model (honours REG_FILE_BYPASS_EN).
`timescale 1ns/1ps
module tb_reg_file_mp;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int NRD      = 2;
  localparam int NWR      = 2;
  localparam int ZERO_REG = 1;
  localparam int AW       = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                clk_en;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NWR-1:0]      rd_wr_en;
  logic [NWR*AW-1:0]   rd_addr;
  logic [NWR*XLEN-1:0] rd_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NREGS-1:0]    busy_vec;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  logic [XLEN-1:0] exp_q [$];

  reg_file_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .rd_wr_en(rd_wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle();
    rd_wr_en   = '0;
    rd_addr    = '0;
    rd_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic set_write(input int j, input int a, input logic [XLEN-1:0] d);
    rd_wr_en[j]             = 1'b1;
    rd_addr[j*AW +: AW]     = a[AW-1:0];
    rd_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_read(input int p, input int a);
    rs_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = a[AW-1:0];
  endtask

  function automatic logic [XLEN-1:0] rdata(input int p);
    return rs_data[p*XLEN +: XLEN];
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int n = 0; n < NREGS; n++) m_regs[n] = '0;
    m_busy = '0;
  endtask

  // Per register: last matching write port supplies the value and clears
  // pending; an allocation of the same register then marks it pending again.
  task automatic model_edge();
    if (!rst_n || !clk_en) return;
    for (int n = 1; n < NREGS; n++) begin
      bit              hit;
      logic [XLEN-1:0] v;
      hit = 0;
      v   = '0;
      for (int j = 0; j < NWR; j++) begin
        if (rd_wr_en[j] && (int'(rd_addr[j*AW +: AW]) == n)) begin
          hit = 1;
          v   = rd_data[j*XLEN +: XLEN];
        end
      end
      if (hit) begin
        m_regs[n] = v;
        m_busy[n] = 1'b0;
      end
      if (alloc_en && (int'(alloc_addr) == n)) m_busy[n] = 1'b1;
    end
  endtask

  function automatic void exp_read(input int a, output logic [XLEN-1:0] d, output logic b);
    if (a == 0) begin
      d = '0;
      b = 1'b0;
      return;
    end
    d = m_regs[a];
    b = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
    if (rst_n && clk_en) begin
      for (int j = 0; j < NWR; j++) begin
        if (rd_wr_en[j] && (int'(rd_addr[j*AW +: AW]) == a)) begin
          d = rd_data[j*XLEN +: XLEN];
          b = alloc_en && (int'(alloc_addr) == a);
        end
      end
    end
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    idle();
    rs_addr = '0;
    set_read(0, 5);
    model_reset();
    #2;
    checks++; if (busy_vec !== '0) begin failures++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec); end
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", rdata(0)); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_write(0, 5, 32'hDEADBEEF);
    set_alloc(5);
    tick();
    idle();
    #1;
    checks++; if (rdata(0) !== 32'hDEADBEEF) begin failures++; $display("FAIL reset_prewrite_x5: got %h expected deadbeef", rdata(0)); end
    checks++; if (busy_vec[5] !== 1'b1) begin failures++; $display("FAIL reset_prealloc_x5: got %b expected 1", busy_vec[5]); end
    // Assert reset mid-cycle while a write and an allocation are pending.
    set_write(0, 5, 32'h0BADF00D);
    set_alloc(6);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL reset_async_x5: got %h expected 0", rdata(0)); end
    checks++; if (busy_vec !== '0) begin failures++; $display("FAIL reset_async_busy: got %h expected 0", busy_vec); end
    checks++; if (rs_busy[0] !== 1'b0) begin failures++; $display("FAIL reset_async_rs_busy: got %b expected 0", rs_busy[0]); end
    @(posedge clk);
    #3;
    idle();
    rst_n = 1'b1;
    tick();
    #1;
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL reset_discard_x5: got %h expected 0", rdata(0)); end
    checks++; if (busy_vec !== '0) begin failures++; $display("FAIL reset_discard_busy: got %h expected 0", busy_vec); end
  endtask

  task automatic test_basic();
    set_write(0, 7, 32'h12345678);
    tick();
    idle();
    set_read(0, 7);
    set_read(1, 7);
    #1;
    checks++; if (rdata(0) !== 32'h12345678) begin failures++; $display("FAIL basic_x7_p0: got %h expected 12345678", rdata(0)); end
    checks++; if (rdata(1) !== 32'h12345678) begin failures++; $display("FAIL basic_x7_p1: got %h expected 12345678", rdata(1)); end
    set_write(1, 0, 32'hFFFFFFFF);
    set_alloc(0);
    set_read(0, 0);
    #1;
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL basic_x0_same_cycle: got %h expected 0", rdata(0)); end
    tick();
    idle();
    #1;
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL basic_x0_data: got %h expected 0", rdata(0)); end
    checks++; if (rs_busy[0] !== 1'b0) begin failures++; $display("FAIL basic_x0_rs_busy: got %b expected 0", rs_busy[0]); end
    checks++; if (busy_vec[0] !== 1'b0) begin failures++; $display("FAIL basic_x0_busy_vec: got %b expected 0", busy_vec[0]); end
    checks++; if (rdata(1) !== 32'h12345678) begin failures++; $display("FAIL basic_x7_keep: got %h expected 12345678", rdata(1)); end
  endtask

  task automatic test_conflict();
    set_write(0, 3, 32'h11);
    set_write(1, 3, 32'h22);
    tick();
    idle();
    set_read(0, 3);
    #1;
    checks++; if (rdata(0) !== 32'h22) begin failures++; $display("FAIL conflict_hi_port_a: got %h expected 22", rdata(0)); end
    set_write(0, 3, 32'h44);
    set_write(1, 3, 32'h33);
    tick();
    idle();
    #1;
    checks++; if (rdata(0) !== 32'h33) begin failures++; $display("FAIL conflict_hi_port_b: got %h expected 33", rdata(0)); end
    set_write(0, 12, 32'hA5A5A5A5);
    set_write(1, 13, 32'h5A5A5A5A);
    tick();
    idle();
    set_read(0, 12);
    set_read(1, 13);
    #1;
    checks++; if (rdata(0) !== 32'hA5A5A5A5) begin failures++; $display("FAIL dual_write_x12: got %h expected a5a5a5a5", rdata(0)); end
    checks++; if (rdata(1) !== 32'h5A5A5A5A) begin failures++; $display("FAIL dual_write_x13: got %h expected 5a5a5a5a", rdata(1)); end
  endtask

  task automatic test_scoreboard();
    set_alloc(9);
    tick();
    idle();
    set_read(0, 9);
    set_read(1, 11);
    #1;
    checks++; if (busy_vec[9] !== 1'b1) begin failures++; $display("FAIL sb_alloc_vec: got %b expected 1", busy_vec[9]); end
    checks++; if (rs_busy[0] !== 1'b1) begin failures++; $display("FAIL sb_alloc_rs_busy: got %b expected 1", rs_busy[0]); end
    set_alloc(9);
    set_write(0, 9, 32'h55);
    tick();
    idle();
    #1;
    checks++; if (busy_vec[9] !== 1'b1) begin failures++; $display("FAIL sb_set_wins: got %b expected 1", busy_vec[9]); end
    checks++; if (rdata(0) !== 32'h55) begin failures++; $display("FAIL sb_set_wins_data: got %h expected 55", rdata(0)); end
    set_write(1, 9, 32'h66);
    tick();
    idle();
    #1;
    checks++; if (busy_vec[9] !== 1'b0) begin failures++; $display("FAIL sb_clear: got %b expected 0", busy_vec[9]); end
    checks++; if (rdata(0) !== 32'h66) begin failures++; $display("FAIL sb_clear_data: got %h expected 66", rdata(0)); end
    set_alloc(9);
    tick();
    set_alloc(9);
    tick();
    idle();
    set_write(0, 9, 32'h77);
    set_write(1, 11, 32'h99);
    tick();
    idle();
    #1;
    checks++; if (busy_vec[9] !== 1'b0) begin failures++; $display("FAIL sb_no_count: got %b expected 0", busy_vec[9]); end
    checks++; if (busy_vec[11] !== 1'b0) begin failures++; $display("FAIL sb_write_not_busy: got %b expected 0", busy_vec[11]); end
    checks++; if (rdata(1) !== 32'h99) begin failures++; $display("FAIL sb_write_not_busy_data: got %h expected 99", rdata(1)); end
  endtask

  task automatic test_clk_en();
    clk_en = 1'b0;
    set_write(0, 4, 32'hAA);
    set_alloc(4);
    set_read(0, 4);
    set_read(1, 9);
    #1;
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL clken_no_forward: got %h expected 0", rdata(0)); end
    tick();
    checks++; if (rdata(0) !== '0) begin failures++; $display("FAIL clken_frozen_data: got %h expected 0", rdata(0)); end
    checks++; if (busy_vec[4] !== 1'b0) begin failures++; $display("FAIL clken_frozen_busy: got %b expected 0", busy_vec[4]); end
    checks++; if (rdata(1) !== 32'h77) begin failures++; $display("FAIL clken_read_live: got %h expected 77", rdata(1)); end
    clk_en = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (rdata(0) !== 32'hAA) begin failures++; $display("FAIL clken_resume_data: got %h expected aa", rdata(0)); end
    checks++; if (busy_vec[4] !== 1'b1) begin failures++; $display("FAIL clken_resume_busy: got %b expected 1", busy_vec[4]); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] e_d;
    logic            e_b;
    set_write(0, 10, 32'h1234);
    set_alloc(10);
    tick();
    idle();
    set_read(0, 10);
    set_read(1, 10);
    set_write(1, 10, 32'hCAFE);
    #1;
`ifdef REG_FILE_BYPASS_EN
    e_d = 32'hCAFE; e_b = 1'b0;
`else
    e_d = 32'h1234; e_b = 1'b1;
`endif
    checks++; if (rdata(0) !== e_d) begin failures++; $display("FAIL bypass_data: got %h expected %h", rdata(0), e_d); end
    checks++; if (rs_busy[0] !== e_b) begin failures++; $display("FAIL bypass_busy: got %b expected %b", rs_busy[0], e_b); end
    checks++; if (busy_vec[10] !== 1'b1) begin failures++; $display("FAIL bypass_vec_registered: got %b expected 1", busy_vec[10]); end
    tick();
    idle();
    #1;
    checks++; if (rdata(1) !== 32'hCAFE) begin failures++; $display("FAIL bypass_after_data: got %h expected cafe", rdata(1)); end
    checks++; if (rs_busy[1] !== 1'b0) begin failures++; $display("FAIL bypass_after_busy: got %b expected 0", rs_busy[1]); end
    set_write(0, 10, 32'hBEEF);
    set_alloc(10);
    #1;
`ifdef REG_FILE_BYPASS_EN
    e_d = 32'hBEEF; e_b = 1'b1;
`else
    e_d = 32'hCAFE; e_b = 1'b0;
`endif
    checks++; if (rdata(0) !== e_d) begin failures++; $display("FAIL bypass_alloc_data: got %h expected %h", rdata(0), e_d); end
    checks++; if (rs_busy[0] !== e_b) begin failures++; $display("FAIL bypass_alloc_busy: got %b expected %b", rs_busy[0], e_b); end
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int a [NRD];
      clk_en = ($urandom_range(0, 7) != 0);
      idle();
      for (int j = 0; j < NWR; j++) begin
        if ($urandom_range(0, 1) == 1)
          set_write(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7), $urandom);
      end
      if ($urandom_range(0, 2) == 0)
        set_alloc(($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) begin
        a[p] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7);
        set_read(p, a[p]);
      end
      #1;
      for (int p = 0; p < NRD; p++) begin
        logic [XLEN-1:0] d;
        logic            b;
        logic [XLEN-1:0] e;
        exp_read(a[p], d, b);
        exp_q.push_back(d);
        e = exp_q.pop_front();
        checks++; if (rdata(p) !== e) begin failures++; $display("FAIL rand_data c=%0d p=%0d x%0d: got %h expected %h", c, p, a[p], rdata(p), e); end
        checks++; if (rs_busy[p] !== b) begin failures++; $display("FAIL rand_busy c=%0d p=%0d x%0d: got %b expected %b", c, p, a[p], rs_busy[p], b); end
      end
      checks++; if (busy_vec !== m_busy) begin failures++; $display("FAIL rand_busy_vec c=%0d: got %h expected %h", c, busy_vec, m_busy); end
      tick();
    end
    clk_en = 1'b1;
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_scoreboard();
    test_clk_en();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
